// File: rtl/alu.sv
// 32-bit integer ALU with registered Result and Zero outputs.
// Operands and opcode are sampled on the rising clock edge.
// Result and Zero change together on that edge.
module alu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALU_operation,
   output logic [WIDTH-1:0] Result,
   output logic             Zero
);

   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_AND = 3'b001,
      OP_OR  = 3'b010,
      OP_XOR = 3'b011,
      OP_SUB = 3'b100,
      OP_NOR = 3'b101,
      OP_SLT = 3'b110,
      OP_SLL = 3'b111
   } alu_op_e;

   alu_op_e          op;
   logic [WIDTH-1:0] result_d;
   logic [WIDTH-1:0] result_q;
   logic             zero_d;
   logic             zero_q;
   logic [SHAMT_W-1:0] shamt;

   assign op    = alu_op_e'(ALU_operation);
   assign shamt = B[SHAMT_W-1:0];

   // Next Result for every opcode; Zero comes from this value, not the old register.
   always_comb begin
      result_d = '0;
      case (op)
         OP_ADD:  result_d = A + B;
         OP_AND:  result_d = A & B;
         OP_OR:   result_d = A | B;
         OP_XOR:  result_d = A ^ B;
         OP_SUB:  result_d = A - B;
         OP_NOR:  result_d = ~(A | B);
         OP_SLT:  result_d[0] = ($signed(A) < $signed(B));
         OP_SLL:  result_d = A << shamt;
         default: result_d = '0;
      endcase
      zero_d = (result_d == '0);
   end

   // Output registers; reset value of Zero matches a cleared Result.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign Result = result_q;
   assign Zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALU_operation;
   logic [31:0] Result;
   logic        Zero;

   int unsigned n_checks;
   int unsigned n_errors;
   logic [31:0] prev_r;
   logic        prev_z;

   alu #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .A             (A),
      .B             (B),
      .ALU_operation (ALU_operation),
      .Result        (Result),
      .Zero          (Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One operation per cycle: drive after negedge, confirm the old outputs still
   // hold before the edge, then check the new outputs just after it.
   task automatic step(input string tag, input logic r, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] exp_r, input logic exp_z);
      @(negedge clk);
      rst = r; A = a; B = b; ALU_operation = op;
      #1;
      check({tag, "_hold_r"}, Result, prev_r);
      check({tag, "_hold_z"}, {31'd0, Zero}, {31'd0, prev_z});
      @(posedge clk);
      #1;
      check({tag, "_r"}, Result, exp_r);
      check({tag, "_z"}, {31'd0, Zero}, {31'd0, exp_z});
      prev_r = exp_r;
      prev_z = exp_z;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; A = 32'd5; B = 32'd7; ALU_operation = 3'b000;
      @(posedge clk);
      #1;
      check("reset_r", Result, 32'h0000_0000);
      check("reset_z", {31'd0, Zero}, 32'd1);
      prev_r = 32'h0; prev_z = 1'b1;

      // Reset overriding live inputs
      step("rst_ovr",  1'b1, 32'd5,        32'd7,        3'b000, 32'h0000_0000, 1'b1);
      // Arithmetic
      step("add",      1'b0, 32'h0000_0001, 32'h0000_0002, 3'b000, 32'h0000_0003, 1'b0);
      step("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 32'h0000_0000, 1'b1);
      step("sub_eq",   1'b0, 32'h0000_0003, 32'h0000_0003, 3'b100, 32'h0000_0000, 1'b1);
      step("sub_ne",   1'b0, 32'h0000_0003, 32'h0000_0004, 3'b100, 32'hFFFF_FFFF, 1'b0);
      // Logic
      step("and",      1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001, 32'h00F0_00F0, 1'b0);
      step("or",       1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, 32'hFFF0_FFF0, 1'b0);
      step("xor",      1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, 32'hFF00_FF00, 1'b0);
      step("nor",      1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b101, 32'h000F_000F, 1'b0);
      // SLT signed
      step("slt_neg",  1'b0, 32'h8000_0000, 32'h0000_0000, 3'b110, 32'h0000_0001, 1'b0);
      step("slt_rev",  1'b0, 32'h0000_0000, 32'h8000_0000, 3'b110, 32'h0000_0000, 1'b1);
      step("slt_eq",   1'b0, 32'h0000_0007, 32'h0000_0007, 3'b110, 32'h0000_0000, 1'b1);
      step("slt_pos",  1'b0, 32'h0000_0002, 32'h7FFF_FFFF, 3'b110, 32'h0000_0001, 1'b0);
      // SLL
      step("sll_4",    1'b0, 32'h0000_0001, 32'h0000_0024, 3'b111, 32'h0000_0010, 1'b0);
      step("sll_0",    1'b0, 32'h1234_5678, 32'h0000_0000, 3'b111, 32'h1234_5678, 1'b0);
      step("sll_31",   1'b0, 32'h0000_0003, 32'h0000_001F, 3'b111, 32'h8000_0000, 1'b0);
      step("sll_hi",   1'b0, 32'h0000_0005, 32'hFFFF_FFE1, 3'b111, 32'h0000_000A, 1'b0);
      step("sll_out",  1'b0, 32'h8000_0000, 32'h0000_0001, 3'b111, 32'h0000_0000, 1'b1);
      // Back-to-back across all opcodes with mid-stream reset
      step("b2b_add",  1'b0, 32'h0000_0010, 32'h0000_0020, 3'b000, 32'h0000_0030, 1'b0);
      step("b2b_and",  1'b0, 32'h0000_00FF, 32'h0000_0F0F, 3'b001, 32'h0000_000F, 1'b0);
      step("b2b_or",   1'b0, 32'h0000_0100, 32'h0000_0001, 3'b010, 32'h0000_0101, 1'b0);
      step("b2b_xor",  1'b0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 3'b011, 32'h0000_0000, 1'b1);
      step("b2b_rst",  1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 3'b101, 32'h0000_0000, 1'b1);
      step("b2b_sub",  1'b0, 32'h0000_0000, 32'h0000_0001, 3'b100, 32'hFFFF_FFFF, 1'b0);
      step("b2b_nor",  1'b0, 32'h0000_0000, 32'h0000_0000, 3'b101, 32'hFFFF_FFFF, 1'b0);
      step("b2b_slt",  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 32'h0000_0001, 1'b0);
      step("b2b_sll",  1'b0, 32'h0000_0003, 32'h0000_0008, 3'b111, 32'h0000_0300, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
